// File: rtl/adc_pkg.sv
// Shared definitions for the ADC frame demultiplexer: the tracker state encoding,
// the index-width helper and the default frame width.
package adc_pkg;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_ALIGN  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int DefAdcRes = 14;
  localparam int DefNumCh  = 4;
  localparam int FrameW    = DefNumCh * DefAdcRes;

  // Ceiling log2; callers guarantee n >= 2, so the result is at least 1.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/adc_sync_tracker.sv
// Frame alignment tracker: walks the channel index, qualifies frame markers,
// counts good frames towards lock and keeps a saturating sync-error count.
module adc_sync_tracker
  import adc_pkg::*;
#(
  parameter int NumCh      = 4,
  parameter int LockFrames = 4,
  parameter int ErrCntW    = 8,
  localparam int IdxW      = clog2(NumCh)
) (
  input  logic               clk_demux_i,
  input  logic               rst_i,
  input  logic               clk_en_i,
  input  logic               frame_i,
  output logic               wr_en,
  output logic [IdxW-1:0]    wr_slot,
  output logic               frame_done,
  output logic               emit,
  output logic               locked,
  output logic               sync_err,
  output logic [ErrCntW-1:0] err_cnt
);

  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumCh - 1);
  localparam logic [3:0]      GoodLast = 4'(LockFrames - 1);

  logic [1:0]         state_reg;
  logic [IdxW-1:0]    idx_reg;
  logic [3:0]         good_reg;
  logic               locked_reg;
  logic               sync_err_reg;
  logic [ErrCntW-1:0] err_cnt_reg;

  logic tracking;
  logic start;
  logic err_a;
  logic err_b;
  logic last;

  always_comb begin
    tracking   = clk_en_i && (state_reg != ST_SEARCH);
    start      = clk_en_i && (state_reg == ST_SEARCH) && frame_i;
    err_a      = tracking && frame_i && (idx_reg != '0);
    err_b      = tracking && !frame_i && (idx_reg == '0);
    last       = (idx_reg == LastIdx);
    frame_done = tracking && !err_a && !err_b && last;
    emit       = frame_done && (state_reg == ST_LOCKED);
    // A marker always lands in slot 0, whether it starts or re-starts a frame.
    wr_en      = start || err_a || (tracking && !err_b && !last);
    wr_slot    = (start || err_a) ? '0 : idx_reg;
  end

  always_ff @(posedge clk_demux_i) begin
    if (rst_i) begin
      state_reg    <= ST_SEARCH;
      idx_reg      <= '0;
      good_reg     <= '0;
      locked_reg   <= 1'b0;
      sync_err_reg <= 1'b0;
      err_cnt_reg  <= '0;
    end else begin
      sync_err_reg <= err_a || err_b;
      if ((err_a || err_b) && (err_cnt_reg != '1))
        err_cnt_reg <= err_cnt_reg + 1'b1;

      if (start) begin
        state_reg <= ST_ALIGN;
        idx_reg   <= IdxW'(1);
      end else if (err_a) begin
        state_reg  <= ST_ALIGN;
        idx_reg    <= IdxW'(1);
        good_reg   <= '0;
        locked_reg <= 1'b0;
      end else if (err_b) begin
        state_reg  <= ST_SEARCH;
        idx_reg    <= '0;
        good_reg   <= '0;
        locked_reg <= 1'b0;
      end else if (tracking) begin
        if (last) begin
          idx_reg <= '0;
          if (state_reg == ST_ALIGN) begin
            if (good_reg == GoodLast) begin
              state_reg  <= ST_LOCKED;
              locked_reg <= 1'b1;
              good_reg   <= '0;
            end else begin
              good_reg <= good_reg + 1'b1;
            end
          end
        end else begin
          idx_reg <= idx_reg + 1'b1;
        end
      end
    end
  end

  assign locked   = locked_reg;
  assign sync_err = sync_err_reg;
  assign err_cnt  = err_cnt_reg;

endmodule

// File: rtl/adc_frame_demux.sv
// Time-interleaved ADC demultiplexer: converts each accepted sample, stages a frame
// and publishes complete frames on a flat per-channel bus once alignment is locked.
module adc_frame_demux
  import adc_pkg::*;
#(
  parameter int AdcRes     = 14,
  parameter int NumCh      = 4,
  parameter int LockFrames = 4,
  parameter int ErrCntW    = 8
) (
  input  logic                    clk_demux_i,
  input  logic                    rst_i,
  input  logic                    clk_en_i,
  input  logic [AdcRes-1:0]       adc_data_i,
  input  logic                    frame_i,
  input  logic                    fmt_twos_i,
  output logic                    valid_o,
  output logic [NumCh*AdcRes-1:0] ch_data_o,
  output logic                    locked_o,
  output logic                    sync_err_o,
  output logic [ErrCntW-1:0]      err_cnt_o
);

  localparam int IdxW   = clog2(NumCh);
  localparam int StageW = (NumCh - 1) * AdcRes;

  logic              wr_en;
  logic [IdxW-1:0]   wr_slot;
  logic              frame_done;
  logic              emit;
  logic [AdcRes-1:0] sample_conv;
  logic [NumCh-2:0]  slot_we;
  logic [StageW-1:0] stage_reg;
  logic [NumCh*AdcRes-1:0] ch_data_reg;
  logic              valid_reg;

  adc_sync_tracker #(
    .NumCh      (NumCh),
    .LockFrames (LockFrames),
    .ErrCntW    (ErrCntW)
  ) u_tracker (
    .clk_demux_i (clk_demux_i),
    .rst_i       (rst_i),
    .clk_en_i    (clk_en_i),
    .frame_i     (frame_i),
    .wr_en       (wr_en),
    .wr_slot     (wr_slot),
    .frame_done  (frame_done),
    .emit        (emit),
    .locked      (locked_o),
    .sync_err    (sync_err_o),
    .err_cnt     (err_cnt_o)
  );

  // Offset-binary to two's complement is just an MSB flip.
  assign sample_conv = {adc_data_i[AdcRes-1] ^ fmt_twos_i, adc_data_i[AdcRes-2:0]};

  generate
    for (genvar gi = 0; gi < NumCh - 1; gi++) begin : g_slot_we
      assign slot_we[gi] = wr_en && (wr_slot == IdxW'(gi));
    end
  endgenerate

  always_ff @(posedge clk_demux_i) begin
    if (rst_i) begin
      stage_reg   <= '0;
      ch_data_reg <= '0;
      valid_reg   <= 1'b0;
    end else begin
      valid_reg <= emit;
      for (int k = 0; k < NumCh - 1; k++) begin
        if (slot_we[k])
          stage_reg[k*AdcRes +: AdcRes] <= sample_conv;
      end
      // The last channel bypasses staging so the frame appears on its own edge.
      if (frame_done && emit)
        ch_data_reg <= {sample_conv, stage_reg};
    end
  end

  assign valid_o   = valid_reg;
  assign ch_data_o = ch_data_reg;

endmodule

// File: tb/tb_adc_frame_demux.sv
// Directed bench for adc_frame_demux: lock acquisition, clock-enable gaps, both
// sync-error kinds, format conversion, error-counter saturation and mid-frame reset.
module tb_adc_frame_demux;

  logic        clk_demux_i = 1'b0;
  logic        rst_i       = 1'b1;
  logic        clk_en_i    = 1'b0;
  logic [13:0] adc_data_i  = '0;
  logic        frame_i     = 1'b0;
  logic        fmt_twos_i  = 1'b0;

  logic        valid_o, locked_o, sync_err_o;
  logic [55:0] ch_data_o;
  logic [7:0]  err_cnt_o;

  logic        valid2, locked2, sync_err2;
  logic [55:0] ch_data2;
  logic [1:0]  err_cnt2;

  int compared   = 0;
  int mismatched = 0;
  int exp_err    = 0;

  always #5 clk_demux_i = ~clk_demux_i;

  adc_frame_demux dut (
    .clk_demux_i (clk_demux_i), .rst_i (rst_i), .clk_en_i (clk_en_i),
    .adc_data_i  (adc_data_i),  .frame_i (frame_i), .fmt_twos_i (fmt_twos_i),
    .valid_o     (valid_o),     .ch_data_o (ch_data_o), .locked_o (locked_o),
    .sync_err_o  (sync_err_o),  .err_cnt_o (err_cnt_o)
  );

  adc_frame_demux #(.ErrCntW(2)) dut2 (
    .clk_demux_i (clk_demux_i), .rst_i (rst_i), .clk_en_i (clk_en_i),
    .adc_data_i  (adc_data_i),  .frame_i (frame_i), .fmt_twos_i (fmt_twos_i),
    .valid_o     (valid2),      .ch_data_o (ch_data2), .locked_o (locked2),
    .sync_err_o  (sync_err2),   .err_cnt_o (err_cnt2)
  );

  function automatic logic [55:0] pack4(input logic [13:0] a0, input logic [13:0] a1,
                                         input logic [13:0] a2, input logic [13:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic en, input logic [13:0] d, input logic f);
    @(negedge clk_demux_i);
    clk_en_i   = en;
    adc_data_i = d;
    frame_i    = f;
    @(posedge clk_demux_i);
    #1;
    $display("t=%0t en=%0b data=%h frame=%0b -> valid=%0b locked=%0b sync_err=%0b err_cnt=%0d ch_data=%h",
             $time, en, d, f, valid_o, locked_o, sync_err_o, err_cnt_o, ch_data_o);
  endtask

  // One clean frame base..base+3; valid is expected only on the last sample if exp_valid.
  task automatic frame4(input logic [13:0] base, input logic exp_valid, input string tag);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, base + 14'(i), i == 0);
      chk({tag, "_valid"}, 64'(valid_o), 64'(exp_valid && (i == 3)));
    end
  endtask

  initial begin
    // Reset state
    cyc(1'b1, 14'h0010, 1'b1);
    cyc(1'b1, 14'h0011, 1'b0);
    chk("rst_valid",   64'(valid_o),    64'd0);
    chk("rst_locked",  64'(locked_o),   64'd0);
    chk("rst_syncerr", 64'(sync_err_o), 64'd0);
    chk("rst_errcnt",  64'(err_cnt_o),  64'd0);
    chk("rst_chdata",  64'(ch_data_o),  64'd0);
    rst_i = 1'b0;

    // Clean stream: lock after frame 4, first strobe after frame 5
    for (int f = 1; f <= 4; f++) begin
      frame4(14'h0010, 1'b0, "align");
      chk("align_locked", 64'(locked_o), 64'(f == 4));
    end
    frame4(14'h0010, 1'b1, "first");
    chk("first_data", 64'(ch_data_o), 64'(pack4(14'h10, 14'h11, 14'h12, 14'h13)));
    frame4(14'h0014, 1'b1, "second");
    chk("second_data", 64'(ch_data_o), 64'(pack4(14'h14, 14'h15, 14'h16, 14'h17)));

    // Clock enable toggling; disabled cycles carry garbage that must be ignored
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 14'h0020 + 14'(i), i == 0);
      chk("en_valid", 64'(valid_o), 64'(i == 3));
      cyc(1'b0, 14'h3FFF, 1'b1);
      chk("dis_valid", 64'(valid_o), 64'd0);
      chk("dis_hold", 64'(ch_data_o), (i == 3) ? 64'(pack4(14'h20, 14'h21, 14'h22, 14'h23))
                                               : 64'(pack4(14'h14, 14'h15, 14'h16, 14'h17)));
    end
    chk("en_locked", 64'(locked_o), 64'd1);

    // Condition A: marker on channel 2 realigns immediately
    cyc(1'b1, 14'h0040, 1'b1);
    cyc(1'b1, 14'h0041, 1'b0);
    cyc(1'b1, 14'h0042, 1'b1);
    exp_err++;
    chk("a_syncerr", 64'(sync_err_o), 64'd1);
    chk("a_errcnt",  64'(err_cnt_o),  64'(exp_err));
    chk("a_locked",  64'(locked_o),   64'd0);
    chk("a_valid",   64'(valid_o),    64'd0);
    cyc(1'b0, 14'h0000, 1'b0);
    chk("a_pulse", 64'(sync_err_o), 64'd0);
    for (int i = 1; i < 4; i++) begin
      cyc(1'b1, 14'h0042 + 14'(i), 1'b0);
      chk("a_tail_valid", 64'(valid_o), 64'd0);
    end
    chk("a_tail_syncerr", 64'(sync_err_o), 64'd0);
    for (int f = 0; f < 3; f++) begin
      frame4(14'h0050, 1'b0, "a_relock");
      chk("a_relock_locked", 64'(locked_o), 64'(f == 2));
    end
    frame4(14'h0060, 1'b1, "a_emit");
    chk("a_emit_data", 64'(ch_data_o), 64'(pack4(14'h60, 14'h61, 14'h62, 14'h63)));

    // Condition B: missing marker drops to search
    cyc(1'b1, 14'h0070, 1'b0);
    exp_err++;
    chk("b_syncerr", 64'(sync_err_o), 64'd1);
    chk("b_errcnt",  64'(err_cnt_o),  64'(exp_err));
    chk("b_locked",  64'(locked_o),   64'd0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 14'h0071 + 14'(i), 1'b0);
    chk("b_search_syncerr", 64'(sync_err_o), 64'd0);
    chk("b_search_errcnt",  64'(err_cnt_o),  64'(exp_err));
    for (int f = 0; f < 4; f++) frame4(14'h0080, 1'b0, "b_relock");
    chk("b_relock_locked", 64'(locked_o), 64'd1);

    // Format conversion
    fmt_twos_i = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b1, 14'h2000, i == 0);
    chk("fmt_valid0", 64'(valid_o),   64'd1);
    chk("fmt_data0",  64'(ch_data_o), 64'd0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 14'h1FFF, i == 0);
    chk("fmt_data1",  64'(ch_data_o), 64'(pack4(14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF)));
    fmt_twos_i = 1'b0;

    // Saturation of the narrow counter: three more Condition-A errors (5 total)
    cyc(1'b1, 14'h0001, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 14'h0002, 1'b1);
      exp_err++;
      chk("sat_errcnt8", 64'(err_cnt_o), 64'(exp_err));
      chk("sat_errcnt2", 64'(err_cnt2),  64'((exp_err > 3) ? 3 : exp_err));
    end

    // Reset mid-frame
    cyc(1'b1, 14'h0011, 1'b0);
    rst_i = 1'b1;
    cyc(1'b1, 14'h0012, 1'b1);
    chk("mrst_valid",   64'(valid_o),    64'd0);
    chk("mrst_locked",  64'(locked_o),   64'd0);
    chk("mrst_syncerr", 64'(sync_err_o), 64'd0);
    chk("mrst_errcnt",  64'(err_cnt_o),  64'd0);
    chk("mrst_errcnt2", 64'(err_cnt2),   64'd0);
    chk("mrst_chdata",  64'(ch_data_o),  64'd0);
    rst_i = 1'b0;
    cyc(1'b1, 14'h0013, 1'b0);
    cyc(1'b1, 14'h0014, 1'b0);
    chk("post_syncerr", 64'(sync_err_o), 64'd0);
    chk("post_errcnt",  64'(err_cnt_o),  64'd0);
    chk("post_valid",   64'(valid_o),    64'd0);
    chk("post_locked2", 64'(locked2),    64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/adc_frame_demux.md
Name: adc_frame_demux

Overview:
- Parametrised successor to the two-channel DDR channel splitter.
- Takes one ADC sample word per enabled cycle, time-interleaved round-robin across NumCh channels, with a frame marker on channel 0.
- Tracks frame alignment and assembles complete frames into a flat per-channel output bus.
- Flags lock status and sync errors, and optionally converts offset-binary to two's complement.
- Sits between the ADC capture stage and downstream DSP/AXI-stream packing.

Parameters:
- AdcRes, 14, sample width in bits.
- NumCh, 4, channels per frame; legal range 2..16.
- LockFrames, 4, consecutive good frames required before lock is declared; legal range 1..15.
- ErrCntW, 8, width of the saturating sync-error counter.

Ports:
- clk_demux_i  in  1  sample clock.
- rst_i  in  1  synchronous reset, active-high.
- clk_en_i  in  1  sample valid; adc_data_i and frame_i are sampled only when this is 1.
- adc_data_i  in  AdcRes  interleaved sample word.
- frame_i  in  1  marks the channel-0 sample; qualified by clk_en_i.
- fmt_twos_i  in  1  when 1, invert each sample MSB (offset-binary to two's complement); sampled per accepted sample.
- valid_o  out  1  one-cycle strobe; ch_data_o holds a new complete frame.
- ch_data_o  out  NumCh*AdcRes  channel k occupies bits [k*AdcRes +: AdcRes].
- locked_o  out  1  alignment locked.
- sync_err_o  out  1  one-cycle pulse per detected alignment error.
- err_cnt_o  out  ErrCntW  saturating count of sync errors.

Behaviour:
- Reset: the following all clear on the reset clock edge: state=SEARCH, channel index idx=0, valid_o=0, locked_o=0, sync_err_o=0, err_cnt_o=0, ch_data_o=0, staging register=0, good-frame counter=0.
- Reset mid-frame discards the partial frame; no valid_o follows reset.
- An accepted sample is one with clk_en_i=1. Cycles with clk_en_i=0 change no state and no output, except that valid_o and sync_err_o return to 0.
- A staging register holds channels 0..NumCh-2. Each converted sample is written to staging slot idx.
- When idx=NumCh-1 is accepted, staging plus the current sample are copied to ch_data_o on the same edge.
- States:
  - SEARCH: ignore samples until an accepted sample has frame_i=1. Store that sample as channel 0, set idx=1, go to ALIGN. No error counting in SEARCH.
  - ALIGN: assemble frames but hold valid_o=0. Each completed good frame increments the good counter. When the count reaches LockFrames, go to LOCKED and set locked_o=1 on the same edge that completes the frame. That frame itself does not produce valid_o.
  - LOCKED: each completed frame updates ch_data_o, and valid_o=1 for exactly one cycle. Latency is 1 clock after the edge accepting channel NumCh-1.
- Sync error, checked in ALIGN and LOCKED:
  - Condition A: accepted sample with frame_i=1 and idx!=0.
  - Condition B: accepted sample with frame_i=0 and idx=0.
- On a sync error:
  - sync_err_o=1 for one cycle; err_cnt_o increments, saturating at all-ones.
  - locked_o=0; good counter clears; partial frame discarded; no valid_o.
  - Condition A: treat the current sample as channel 0, set idx=1, go to ALIGN (immediate realign).
  - Condition B: go to SEARCH; the sample is dropped.
- idx wraps NumCh-1 → 0 after each completed frame. Its width is clog2(NumCh).
- The simultaneous frame-complete and error case cannot occur: idx=NumCh-1 with frame_i=1 is Condition A and takes priority. The frame is not emitted.
- Format conversion is purely a per-sample MSB flip applied before staging. Channels within one frame may have mixed formats if fmt_twos_i toggles mid-frame; this is legal.
- ch_data_o holds its value between valid_o strobes and across loss of lock.

Decomposition:
- Shared package adc_pkg holds:
  - the state encoding (SEARCH=2'd0, ALIGN=2'd1, LOCKED=2'd2);
  - a clog2 function for the idx width;
  - the localparam FrameW=NumCh*AdcRes.
- One sub-module is natural: adc_sync_tracker (state machine, idx counter, good counter, error counter). It outputs the slot index, frame_done, emit and locked.
- Sample conversion, staging and output registers stay in the top level.

Test Plan:
- Reset then clean stream, NumCh=4, LockFrames=4, samples 0x0010..0x0013 with frame_i on 0x0010, repeated → locked_o rises at end of frame 4. valid_o is first seen after frame 5, with ch_data_o = {0x0013,0x0012,0x0011,0x0010}. Thereafter one strobe per 4 accepted samples.
- Same stream with clk_en_i toggling 1,0,1,0 → identical ch_data_o values. valid_o strobes every 8 cycles; nothing advances on disabled cycles.
- While locked, assert frame_i on channel 2 → sync_err_o pulse, err_cnt_o=1, locked_o=0, that sample becomes channel 0. After 4 good frames, locked_o=1 again with no valid_o in between.
- While locked, drop frame_i on a channel-0 sample → sync_err_o pulse, state SEARCH. Recovery starts only at the next frame_i=1.
- fmt_twos_i=1, input 0x2000 on all channels → ch_data_o lanes = 0x0000. Input 0x1FFF → lanes = 0x3FFF.
- ErrCntW=2, inject 5 errors → err_cnt_o saturates at 3. Assert rst_i mid-frame → all outputs 0 on the next edge, state SEARCH.
